// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader
// Streams a bitstream, word by word and MSB first, into a configuration
// flip-flop chain. A pass runs IDLE -> FETCH -> SHIFT -> (FETCH ...) -> DONE.
// It falls to ERROR if the word source stalls for TIMEOUT consecutive cycles.
// The user fabric is held in reset in every state except DONE.
module ccff_bitstream_loader #(
    parameter int CHAIN_LEN = 16,
    parameter int WORD_W    = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              prog_en,
    output logic              fabric_rst,
    output logic              busy,
    output logic              done,
    output logic              error
);

    // Counter widths are chosen so that each counter can hold its terminal
    // value. A counter never increments past that value.
    localparam int BIT_W  = $clog2(CHAIN_LEN + 1);
    localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam int WB_W   = $clog2(WORD_W + 1);

    localparam logic [BIT_W:0]  BIT_LIMIT  = (BIT_W + 1)'(CHAIN_LEN);
    localparam logic [WAIT_W:0] WAIT_LIMIT = (WAIT_W + 1)'(TIMEOUT);
    localparam logic [WB_W:0]   WB_LIMIT   = (WB_W + 1)'(WORD_W);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_SHIFT = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [WB_W-1:0]     word_bit_q, word_bit_d;
    logic [WORD_W-1:0]   shreg_q, shreg_d;

    logic                accept;
    logic                bit_last;
    logic                word_last;
    logic                wait_expired;
    logic [BIT_W:0]      bit_inc;
    logic [WAIT_W:0]     wait_inc;
    logic [WB_W:0]       wb_inc;

    // Incremented counter values and the terminal-count decodes.
    // Each decode is true on the edge where its counter would reach its limit.
    always_comb begin
        bit_inc      = {1'b0, bit_cnt_q} + (BIT_W + 1)'(1);
        wait_inc     = {1'b0, wait_cnt_q} + (WAIT_W + 1)'(1);
        wb_inc       = {1'b0, word_bit_q} + (WB_W + 1)'(1);
        bit_last     = (bit_inc == BIT_LIMIT);
        word_last    = (wb_inc == WB_LIMIT);
        wait_expired = (wait_inc >= WAIT_LIMIT);
        accept       = (state_q == S_FETCH) && word_valid;
    end

    // State and datapath registers. Reset wins over every other input,
    // including a start asserted on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            wait_cnt_q <= '0;
            word_bit_q <= '0;
            shreg_q    <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            word_bit_q <= word_bit_d;
            shreg_q    <= shreg_d;
        end
    end

    // Next state. An accepted word takes priority over the stall timeout.
    // The chain-length limit takes priority over the end of a word.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (accept) begin
                    state_d = S_SHIFT;
                end else if (wait_expired) begin
                    state_d = S_ERROR;
                end
            end
            S_SHIFT: begin
                if (bit_last) begin
                    state_d = S_DONE;
                end else if (word_last) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Next values for the counters and the shift register.
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        wait_cnt_d = wait_cnt_q;
        word_bit_d = word_bit_q;
        shreg_d    = shreg_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    bit_cnt_d  = '0;
                    wait_cnt_d = '0;
                    word_bit_d = '0;
                end
            end
            S_FETCH: begin
                if (accept) begin
                    shreg_d    = word_data;
                    wait_cnt_d = '0;
                    word_bit_d = '0;
                end else begin
                    // A stalled FETCH leaves on the edge where this count
                    // reaches TIMEOUT, so the count cannot wrap.
                    wait_cnt_d = wait_inc[WAIT_W-1:0];
                end
            end
            S_SHIFT: begin
                shreg_d    = shreg_q << 1;
                bit_cnt_d  = bit_inc[BIT_W-1:0];
                word_bit_d = wb_inc[WB_W-1:0];
            end
            default: begin
                bit_cnt_d  = '0;
                wait_cnt_d = '0;
                word_bit_d = '0;
                shreg_d    = '0;
            end
        endcase
    end

    // Moore outputs, decoded from the current state only.
    always_comb begin
        word_ready = 1'b0;
        prog_en    = 1'b0;
        ccff_head  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        fabric_rst = 1'b1;
        case (state_q)
            S_FETCH: begin
                word_ready = 1'b1;
                busy       = 1'b1;
            end
            S_SHIFT: begin
                busy       = 1'b1;
                prog_en    = 1'b1;
                ccff_head  = shreg_q[WORD_W-1];
            end
            S_DONE: begin
                done       = 1'b1;
                fabric_rst = 1'b0;
            end
            S_ERROR: begin
                error      = 1'b1;
            end
            default: begin
                fabric_rst = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Directed bench for ccff_bitstream_loader. Accepted words are expanded into
// expected head bits on a scoreboard queue. The queue is drained whenever a
// DUT drives prog_en.
module tb_ccff_bitstream_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start0, wv0, rdy0, head0, pe0, frst0, busy0, done0, err0;
    logic [7:0] wd0;
    logic       start1, wv1, rdy1, head1, pe1, frst1, busy1, done1, err1;
    logic [7:0] wd1;

    int tests = 0;
    int fails = 0;
    int npe0  = 0;
    int npe1  = 0;
    int n     = 0;

    logic       exp0[$];
    logic       exp1[$];
    logic [7:0] w0[$];
    logic [7:0] w1[$];

    ccff_bitstream_loader u0 (
        .clk(clk), .reset(reset), .start(start0), .word_valid(wv0), .word_data(wd0),
        .word_ready(rdy0), .ccff_head(head0), .prog_en(pe0), .fabric_rst(frst0),
        .busy(busy0), .done(done0), .error(err0)
    );

    ccff_bitstream_loader #(.CHAIN_LEN(12), .WORD_W(8), .TIMEOUT(255)) u1 (
        .clk(clk), .reset(reset), .start(start1), .word_valid(wv1), .word_data(wd1),
        .word_ready(rdy1), .ccff_head(head1), .prog_en(pe1), .fabric_rst(frst1),
        .busy(busy1), .done(done1), .error(err1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_rst0(input string tag);
        chk({tag, "_rdy0"},  rdy0,  0);
        chk({tag, "_pe0"},   pe0,   0);
        chk({tag, "_head0"}, head0, 0);
        chk({tag, "_busy0"}, busy0, 0);
        chk({tag, "_done0"}, done0, 0);
        chk({tag, "_err0"},  err0,  0);
        chk({tag, "_frst0"}, frst0, 1);
    endtask

    // One clock edge. The task notes which words are accepted, samples 1ns
    // after the edge, checks head bits against the scoreboard, and then
    // presents the next queued word.
    task automatic tick();
        logic       acc0, acc1, b;
        logic [7:0] w;
        acc0 = wv0 && rdy0 && !reset;
        acc1 = wv1 && rdy1 && !reset;
        @(posedge clk);
        #1;
        if (acc0 && w0.size() > 0) begin
            w = w0.pop_front();
            for (int i = 7; i >= 0; i--) exp0.push_back(w[i]);
        end
        if (acc1 && w1.size() > 0) begin
            w = w1.pop_front();
            for (int i = 7; i >= 0; i--) exp1.push_back(w[i]);
        end
        if (pe0) begin
            npe0++;
            if (exp0.size() > 0) begin
                b = exp0.pop_front();
                chk("head0_bit", head0, b);
            end else begin
                chk("pe0_unexpected", pe0, 0);
            end
        end else begin
            chk("head0_quiet", head0, 0);
        end
        if (pe1) begin
            npe1++;
            if (exp1.size() > 0) begin
                b = exp1.pop_front();
                chk("head1_bit", head1, b);
            end else begin
                chk("pe1_unexpected", pe1, 0);
            end
        end else begin
            chk("head1_quiet", head1, 0);
        end
        wd0 = (w0.size() > 0) ? w0[0] : 8'h00;
        wd1 = (w1.size() > 0) ? w1[0] : 8'h00;
    endtask

    initial begin
        reset = 1'b1; start0 = 1'b0; start1 = 1'b0;
        wv0 = 1'b0; wv1 = 1'b0; wd0 = 8'h00; wd1 = 8'h00;

        // Reset state, while reset is held and after it is released
        tick(); tick();
        chk_rst0("rst_hold");
        chk("rst_hold_frst1", frst1, 1);
        chk("rst_hold_busy1", busy1, 0);
        reset = 1'b0;
        tick();
        chk_rst0("rst_after");

        // Default pass: 0xA5 then 0x3C with word_valid held high
        w0.push_back(8'hA5); w0.push_back(8'h3C); wd0 = 8'hA5; wv0 = 1'b1; npe0 = 0;
        start0 = 1'b1; tick(); start0 = 1'b0; n = 0;
        chk("t35_busy", busy0, 1);
        chk("t35_rdy", rdy0, 1);
        chk("t35_frst", frst0, 1);
        while (!done0 && n < 60) begin tick(); n++; end
        chk("t35_edges", n, 18);
        chk("t35_npe", npe0, 16);
        chk("t35_left", exp0.size(), 0);
        chk("t35_done", done0, 1);
        chk("t35_frst_done", frst0, 0);
        chk("t35_busy_done", busy0, 0);

        // A start pulse during SHIFT must not disturb the pass
        w0.push_back(8'hA5); w0.push_back(8'h3C); npe0 = 0;
        start0 = 1'b1; tick(); start0 = 1'b0; n = 0;
        repeat (4) begin tick(); n++; end
        chk("t39_in_shift", pe0, 1);
        start0 = 1'b1; tick(); n++; start0 = 1'b0;
        while (!done0 && n < 60) begin tick(); n++; end
        chk("t39_edges", n, 18);
        chk("t39_npe", npe0, 16);
        chk("t39_left", exp0.size(), 0);
        chk("t39_done", done0, 1);

        // CHAIN_LEN=12: the pass stops mid-word and drops 4 bits of 0xF0
        w1.push_back(8'hFF); w1.push_back(8'hF0); wd1 = 8'hFF; wv1 = 1'b1; npe1 = 0;
        start1 = 1'b1; tick(); start1 = 1'b0; n = 0;
        while (!done1 && n < 60) begin tick(); n++; end
        chk("t36_edges", n, 14);
        chk("t36_npe", npe1, 12);
        chk("t36_dropped", exp1.size(), 4);
        chk("t36_done", done1, 1);
        chk("t36_frst", frst1, 0);
        chk("t36_err", err1, 0);

        // Stall timeout: no word for 255 FETCH edges
        wv0 = 1'b0;
        start0 = 1'b1; tick(); start0 = 1'b0; n = 0;
        while (n < 254) begin tick(); n++; end
        chk("t37_pre_err", err0, 0);
        chk("t37_pre_busy", busy0, 1);
        tick(); n++;
        chk("t37_err", err0, 1);
        chk("t37_busy", busy0, 0);
        chk("t37_frst", frst0, 1);
        chk("t37_done", done0, 0);
        chk("t37_rdy", rdy0, 0);

        // Restart from ERROR; the full timeout window applies again
        start0 = 1'b1; tick(); start0 = 1'b0; n = 0;
        chk("t37_restart_rdy", rdy0, 1);
        chk("t37_restart_err", err0, 0);
        chk("t37_restart_busy", busy0, 1);
        while (n < 254) begin tick(); n++; end
        chk("t40_still_fetch", rdy0, 1);
        chk("t40_pre_err", err0, 0);

        // The word arrives on the timeout edge and is accepted
        w0.push_back(8'hA5); w0.push_back(8'h3C); wd0 = 8'hA5; wv0 = 1'b1; npe0 = 0;
        tick(); n++;
        chk("t40_no_err", err0, 0);
        chk("t40_accept", pe0, 1);
        while (!done0 && n < 320) begin tick(); n++; end
        chk("t40_edges", n, 272);
        chk("t40_npe", npe0, 16);
        chk("t40_left", exp0.size(), 0);
        chk("t40_err_done", err0, 0);

        // Reset during bit 5 of the second word, then a clean restart
        w0.push_back(8'hA5); w0.push_back(8'h3C); wd0 = 8'hA5; npe0 = 0;
        start0 = 1'b1; tick(); start0 = 1'b0; n = 0;
        while (n < 15) begin tick(); n++; end
        chk("t38_mid_shift", pe0, 1);
        reset = 1'b1;
        tick();
        chk_rst0("t38_rst");
        exp0.delete(); w0.delete();
        reset = 1'b0;
        tick();
        chk_rst0("t38_idle");
        w0.push_back(8'hA5); w0.push_back(8'h3C); wd0 = 8'hA5; npe0 = 0;
        start0 = 1'b1; tick(); start0 = 1'b0; n = 0;
        while (!done0 && n < 60) begin tick(); n++; end
        chk("t38_edges", n, 18);
        chk("t38_npe", npe0, 16);
        chk("t38_left", exp0.size(), 0);
        chk("t38_done", done0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
